// File: rtl/jt6295_rom_arb_if.sv
// Bus bundle between the JT6295 ROM arbiter, its requesters and the sample ROM.
// The arbiter uses the slave modport; the requester/ROM side uses master.
interface jt6295_rom_arb_if;
    logic        ctrl_req;
    logic [9:0]  ctrl_addr;
    logic        ctrl_ack;
    logic [3:0]  ch_req;
    logic [71:0] ch_addr;
    logic [3:0]  ch_ack;
    logic [7:0]  dout;
    logic [17:0] rom_addr;
    logic        rom_cs;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic        busy;
    logic        tout_err;

    modport slave (
        input  ctrl_req, ctrl_addr, ch_req, ch_addr, rom_data, rom_ok,
        output ctrl_ack, ch_ack, dout, rom_addr, rom_cs, busy, tout_err
    );

    modport master (
        output ctrl_req, ctrl_addr, ch_req, ch_addr, rom_data, rom_ok,
        input  ctrl_ack, ch_ack, dout, rom_addr, rom_cs, busy, tout_err
    );
endinterface

// File: rtl/jt6295_rom_arb.sv
// Single-port ADPCM sample ROM arbiter: the controller has fixed priority,
// the four channels share the remaining slots round-robin, one access at a time.
module jt6295_rom_arb #(
    parameter int SETTLE = 1,
    parameter int TOUT   = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    jt6295_rom_arb_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WAIT
    } state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
    localparam logic [15:0] TOUT_LAST   = 16'(TOUT - 1);
    localparam bit          SETTLE_EN   = (SETTLE != 0);
    localparam bit          TOUT_EN     = (TOUT != 0);

    state_t      state;
    state_t      next_state;
    logic [15:0] cnt;

    logic [17:0] ch_addr_a [4];
    logic        ctrl_cand;
    logic [3:0]  ch_cand;
    logic        win_ctrl;
    logic [3:0]  win_ch;
    logic [17:0] win_addr;
    logic        found;
    logic [1:0]  idx;

    logic        gnt_ctrl;
    logic [3:0]  gnt_ch;
    logic        mask_ctrl;
    logic [3:0]  mask_ch;
    logic [1:0]  last_ch;

    logic        grant;
    logic        done_ok;
    logic        done_tout;
    logic        busy_c;

    logic [17:0] rom_addr_q;
    logic        rom_cs_q;
    logic [7:0]  dout_q;
    logic        ctrl_ack_q;
    logic [3:0]  ch_ack_q;
    logic        tout_err_q;

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            ch_addr_a[n] = bus.ch_addr[18*n +: 18];
        end
    end

    // The mask hides the requester acked last, for one IDLE cycle only.
    always_comb begin
        ctrl_cand = bus.ctrl_req & ~mask_ctrl;
        ch_cand   = bus.ch_req & ~mask_ch;
        win_ctrl  = 1'b0;
        win_ch    = 4'b0000;
        win_addr  = 18'd0;
        found     = 1'b0;
        idx       = 2'd0;
        if (ctrl_cand) begin
            win_ctrl = 1'b1;
            win_addr = {8'd0, bus.ctrl_addr};
        end else begin
            for (int k = 1; k <= 4; k++) begin
                idx = last_ch + 2'(k);
                if (!found && ch_cand[idx]) begin
                    found       = 1'b1;
                    win_ch[idx] = 1'b1;
                    win_addr    = ch_addr_a[idx];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        done_ok    = 1'b0;
        done_tout  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_ctrl || (|win_ch)) begin
                    grant      = 1'b1;
                    next_state = SETTLE_EN ? ST_SETTLE : ST_WAIT;
                end
            end
            ST_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.rom_ok) begin
                    done_ok    = 1'b1;
                    next_state = ST_IDLE;
                end else if (TOUT_EN && (cnt == TOUT_LAST)) begin
                    done_tout  = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state != ST_IDLE);
    end

    // One counter serves both the settle window and the timeout; it restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 16'd0;
            rom_addr_q <= 18'd0;
            rom_cs_q   <= 1'b0;
            dout_q     <= 8'd0;
            ctrl_ack_q <= 1'b0;
            ch_ack_q   <= 4'b0000;
            tout_err_q <= 1'b0;
            gnt_ctrl   <= 1'b0;
            gnt_ch     <= 4'b0000;
            mask_ctrl  <= 1'b0;
            mask_ch    <= 4'b0000;
            last_ch    <= 2'd3;
        end else begin
            ctrl_ack_q <= 1'b0;
            ch_ack_q   <= 4'b0000;
            tout_err_q <= 1'b0;

            if ((state == next_state) && (state != ST_IDLE)) begin
                cnt <= cnt + 16'd1;
            end else begin
                cnt <= 16'd0;
            end

            if (state == ST_IDLE) begin
                mask_ctrl <= 1'b0;
                mask_ch   <= 4'b0000;
            end

            if (grant) begin
                rom_addr_q <= win_addr;
                rom_cs_q   <= 1'b1;
                gnt_ctrl   <= win_ctrl;
                gnt_ch     <= win_ch;
            end

            if (done_ok || done_tout) begin
                dout_q     <= done_ok ? bus.rom_data : 8'h00;
                ctrl_ack_q <= gnt_ctrl;
                ch_ack_q   <= gnt_ch;
                tout_err_q <= done_tout;
                rom_cs_q   <= 1'b0;
                mask_ctrl  <= gnt_ctrl;
                mask_ch    <= gnt_ch;
                if (!gnt_ctrl) begin
                    last_ch <= {gnt_ch[3] | gnt_ch[2], gnt_ch[3] | gnt_ch[1]};
                end
            end
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.rom_cs   = rom_cs_q;
    assign bus.dout     = dout_q;
    assign bus.ctrl_ack = ctrl_ack_q;
    assign bus.ch_ack   = ch_ack_q;
    assign bus.tout_err = tout_err_q;
    assign bus.busy     = busy_c;

endmodule

// File: tb/tb_jt6295_rom_arb.sv
// Directed bench for jt6295_rom_arb (SETTLE=1, TOUT=8): priority, round-robin,
// settle window, timeout and asynchronous reset abort.
module tb_jt6295_rom_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rom_echo;
    logic [7:0] rom_byte;
    int         checks = 0;
    int         errors = 0;

    localparam logic [17:0] CH_ADDR [4] = '{18'h00A10, 18'h01B21, 18'h02C32, 18'h03D43};

    jt6295_rom_arb_if bus();

    // ROM either echoes the low address byte or returns a fixed byte.
    assign bus.rom_data = rom_echo ? bus.rom_addr[7:0] : rom_byte;

    always #5 clk = ~clk;

    jt6295_rom_arb #(
        .SETTLE (1),
        .TOUT   (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic creq, input logic [9:0] caddr,
                                  input logic [3:0] chreq, input logic ok);
        bus.ctrl_req  = creq;
        bus.ctrl_addr = caddr;
        bus.ch_req    = chreq;
        bus.rom_ok    = ok;
    endtask

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};

        rst_n       = 1'b0;
        rom_echo    = 1'b0;
        rom_byte    = 8'h00;
        bus.ch_addr = {CH_ADDR[3], CH_ADDR[2], CH_ADDR[1], CH_ADDR[0]};
        apply_stimulus(1'b0, 10'h000, 4'b0000, 1'b0);
        tick();
        tick();

        check_output("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
        check_output("rst_rom_cs",   32'(bus.rom_cs),   32'h0);
        check_output("rst_dout",     32'(bus.dout),     32'h0);
        check_output("rst_ctrl_ack", 32'(bus.ctrl_ack), 32'h0);
        check_output("rst_ch_ack",   32'(bus.ch_ack),   32'h0);
        check_output("rst_busy",     32'(bus.busy),     32'h0);
        check_output("rst_tout_err", 32'(bus.tout_err), 32'h0);
        rst_n = 1'b1;
        tick();
        check_output("idle_busy", 32'(bus.busy), 32'h0);

        // Single controller read, rom_ok constantly high.
        rom_byte = 8'h3C;
        apply_stimulus(1'b1, 10'h005, 4'b0000, 1'b1);
        tick();
        check_output("t1_rom_addr", 32'(bus.rom_addr), 32'h00005);
        check_output("t1_rom_cs",   32'(bus.rom_cs),   32'h1);
        check_output("t1_busy",     32'(bus.busy),     32'h1);
        tick();
        check_output("t1_early_ack", 32'(bus.ctrl_ack), 32'h0);
        tick();
        check_output("t1_ctrl_ack", 32'(bus.ctrl_ack), 32'h1);
        check_output("t1_dout",     32'(bus.dout),     32'h3C);
        check_output("t1_cs_drop",  32'(bus.rom_cs),   32'h0);
        check_output("t1_ch_ack",   32'(bus.ch_ack),   32'h0);
        apply_stimulus(1'b0, 10'h000, 4'b0000, 1'b1);
        tick();
        check_output("t1_ack_pulse", 32'(bus.ctrl_ack), 32'h0);
        check_output("t1_dout_hold", 32'(bus.dout),     32'h3C);

        // All four channels requesting: expect 0,1,2,3,0.
        rom_echo = 1'b1;
        apply_stimulus(1'b0, 10'h000, 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("t2_rom_addr", 32'(bus.rom_addr), 32'(CH_ADDR[order[i]]));
            check_output("t2_rom_cs",   32'(bus.rom_cs),   32'h1);
            tick();
            check_output("t2_no_ack", 32'(bus.ch_ack), 32'h0);
            tick();
            check_output("t2_ch_ack", 32'(bus.ch_ack), 32'd1 << order[i]);
            check_output("t2_dout",   32'(bus.dout),   32'(CH_ADDR[order[i]][7:0]));
            check_output("t2_idle",   32'(bus.busy),   32'h0);
        end
        apply_stimulus(1'b0, 10'h000, 4'b0000, 1'b1);
        tick();
        check_output("t2_end_busy", 32'(bus.busy), 32'h0);

        // Controller arrives during channel 1's access.
        apply_stimulus(1'b0, 10'h000, 4'b0110, 1'b1);
        tick();
        check_output("t3_ch1_addr", 32'(bus.rom_addr), 32'h01B21);
        apply_stimulus(1'b1, 10'h2F3, 4'b0110, 1'b1);
        tick();
        tick();
        check_output("t3_ch1_ack",  32'(bus.ch_ack),   32'h2);
        check_output("t3_ctrl_no",  32'(bus.ctrl_ack), 32'h0);
        check_output("t3_ch1_dout", 32'(bus.dout),     32'h21);
        tick();
        check_output("t3_ctrl_addr", 32'(bus.rom_addr), 32'h002F3);
        tick();
        tick();
        check_output("t3_ctrl_ack",  32'(bus.ctrl_ack), 32'h1);
        check_output("t3_ctrl_chno", 32'(bus.ch_ack),   32'h0);
        check_output("t3_ctrl_dout", 32'(bus.dout),     32'hF3);
        apply_stimulus(1'b0, 10'h000, 4'b0110, 1'b1);
        tick();
        check_output("t3_ch2_addr", 32'(bus.rom_addr), 32'h02C32);
        tick();
        tick();
        check_output("t3_ch2_ack",  32'(bus.ch_ack), 32'h4);
        check_output("t3_ch2_dout", 32'(bus.dout),   32'h32);
        apply_stimulus(1'b0, 10'h000, 4'b0100, 1'b1);
        tick();
        check_output("t3_mask_busy", 32'(bus.busy),   32'h0);
        check_output("t3_mask_cs",   32'(bus.rom_cs), 32'h0);
        apply_stimulus(1'b0, 10'h000, 4'b0000, 1'b1);
        tick();

        // rom_ok pulse inside the settle window, then 5 low cycles in WAIT.
        rom_echo = 1'b0;
        rom_byte = 8'h9E;
        apply_stimulus(1'b1, 10'h123, 4'b0000, 1'b0);
        tick();
        check_output("t4_rom_addr", 32'(bus.rom_addr), 32'h00123);
        bus.rom_ok = 1'b1;
        tick();
        check_output("t4_settle_ignore", 32'(bus.ctrl_ack), 32'h0);
        check_output("t4_busy",          32'(bus.busy),     32'h1);
        bus.rom_ok = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            check_output("t4_wait_no_ack", 32'(bus.ctrl_ack), 32'h0);
        end
        bus.rom_ok = 1'b1;
        tick();
        check_output("t4_ctrl_ack", 32'(bus.ctrl_ack), 32'h1);
        check_output("t4_dout",     32'(bus.dout),     32'h9E);
        check_output("t4_no_tout",  32'(bus.tout_err), 32'h0);
        apply_stimulus(1'b0, 10'h000, 4'b0000, 1'b0);
        tick();

        // Timeout on channel 3 with rom_ok stuck low.
        rom_byte = 8'h77;
        apply_stimulus(1'b0, 10'h000, 4'b1000, 1'b0);
        tick();
        check_output("t5_rom_addr", 32'(bus.rom_addr), 32'h03D43);
        tick();
        for (int j = 0; j < 7; j++) begin
            tick();
            check_output("t5_no_ack",  32'(bus.ch_ack),   32'h0);
            check_output("t5_no_tout", 32'(bus.tout_err), 32'h0);
        end
        tick();
        check_output("t5_ch3_ack", 32'(bus.ch_ack),   32'h8);
        check_output("t5_tout",    32'(bus.tout_err), 32'h1);
        check_output("t5_dout",    32'(bus.dout),     32'h00);
        rom_echo = 1'b1;
        apply_stimulus(1'b0, 10'h000, 4'b0001, 1'b1);
        tick();
        check_output("t5_tout_pulse", 32'(bus.tout_err), 32'h0);
        check_output("t5_next_addr",  32'(bus.rom_addr), 32'h00A10);
        check_output("t5_next_cs",    32'(bus.rom_cs),   32'h1);
        tick();
        tick();
        check_output("t5_next_ack",  32'(bus.ch_ack), 32'h1);
        check_output("t5_next_dout", 32'(bus.dout),   32'h10);
        apply_stimulus(1'b0, 10'h000, 4'b0000, 1'b0);
        tick();

        // Asynchronous reset while waiting on channel 2.
        apply_stimulus(1'b0, 10'h000, 4'b0100, 1'b0);
        tick();
        check_output("t6_ch2_addr", 32'(bus.rom_addr), 32'h02C32);
        tick();
        tick();
        check_output("t6_wait_cs",   32'(bus.rom_cs), 32'h1);
        check_output("t6_wait_busy", 32'(bus.busy),   32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("t6_async_cs",   32'(bus.rom_cs),   32'h0);
        check_output("t6_async_addr", 32'(bus.rom_addr), 32'h0);
        check_output("t6_async_dout", 32'(bus.dout),     32'h0);
        check_output("t6_async_busy", 32'(bus.busy),     32'h0);
        check_output("t6_async_ack",  32'(bus.ch_ack),   32'h0);
        apply_stimulus(1'b0, 10'h000, 4'b0101, 1'b1);
        tick();
        tick();
        check_output("t6_rst_no_ack", 32'(bus.ch_ack), 32'h0);
        rst_n = 1'b1;
        tick();
        check_output("t6_ch0_first", 32'(bus.rom_addr), 32'h00A10);
        tick();
        tick();
        check_output("t6_ch0_ack",  32'(bus.ch_ack), 32'h1);
        check_output("t6_ch0_dout", 32'(bus.dout),   32'h10);
        apply_stimulus(1'b0, 10'h000, 4'b0000, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jt6295_rom_arb.md
Name: jt6295_rom_arb

Overview:
- Shares the single 8-bit ADPCM sample ROM port between the phrase-table controller and the four ADPCM channel fetchers.
- Only one ROM access is outstanding at a time. The controller has fixed highest priority; the channels are served round-robin.
- Each access returns one byte to the winning requester together with a one-cycle acknowledge.
- Sits between the controller/channel blocks and the top-level ROM interface.

Parameters:
- SETTLE, 1: clk cycles after a new rom_addr during which rom_ok is ignored. Range 0..7.
- TOUT, 0: clk cycles waiting for rom_ok before the access is abandoned. 0 disables the timeout. 16-bit counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ctrl_req  in  1  controller read request; held high until ctrl_ack
- ctrl_addr  in  10  phrase-table byte address; maps to rom_addr = {8'd0, ctrl_addr}
- ctrl_ack  out  1  one-cycle pulse; dout is valid in this cycle
- ch_req  in  4  channel read requests; bit n is channel n
- ch_addr  in  72  packed channel addresses; channel n uses bits [18n+17:18n]
- ch_ack  out  4  one-hot one-cycle acknowledge
- dout  out  8  byte returned for the acknowledged access; holds its value between accesses
- rom_addr  out  18  ROM byte address
- rom_cs  out  1  high while an access is in progress
- rom_data  in  8  ROM data
- rom_ok  in  1  rom_data is valid for the current rom_addr
- busy  out  1  high in every state except IDLE
- tout_err  out  1  one-cycle pulse when an access is abandoned

Behaviour:
- Reset values (async, rst_n=0): rom_addr=0, rom_cs=0, dout=0, all acks 0, busy=0, tout_err=0, state=IDLE, last_ch=3 (so channel 0 wins first), mask=0.
- A reset asserted mid-access aborts it at once: no ack is issued and rom_cs drops.
- State IDLE:
  - Candidates are the requests with the mask removed.
  - If ctrl_req is a candidate, the controller wins.
  - Otherwise the first set channel searching last_ch+1, +2, +3, +4 (mod 4) wins.
  - On a win, the registered outputs are set: rom_addr <= selected address, rom_cs <= 1, gnt <= winner. Next state is SETTLE, or WAIT when SETTLE=0.
  - With no request, the block stays in IDLE and mask clears.
- State SETTLE: a counter runs for SETTLE cycles and rom_ok is ignored. Then go to WAIT.
- State WAIT:
  - On rom_ok=1: dout <= rom_data; pulse the ack of gnt; rom_cs <= 0; go to IDLE.
  - If gnt is a channel, last_ch <= gnt.
  - mask <= the acked requester, for the single following IDLE cycle. This absorbs registered requesters still holding req for one cycle after ack.
- Timeout (TOUT>0 only): the counter starts when WAIT is entered. When it reaches TOUT without rom_ok, the block behaves as a normal ack except dout <= 8'h00 and tout_err pulses in the same cycle. last_ch and mask update as normal.
- Latency: ack is registered. With rom_ok already high, ack arrives SETTLE+2 cycles after req is first sampled in IDLE. Back-to-back accesses are separated by at least one IDLE cycle.
- Request-handshake boundaries:
  - A req dropped mid-access does not abort the access; the ack is still issued.
  - The address is latched at grant, so address changes after grant are ignored.
- Simultaneous ctrl_req and ch_req: the controller always wins; channel round-robin state is unchanged.
- Starvation bound for a channel: if ctrl_req stays idle, a channel is served within 4 accesses.

Test Plan:
- Single ctrl read, ctrl_addr=10'h005, ROM returns 8'h3C with rom_ok constant 1, SETTLE=1 -> rom_addr=18'h00005; ctrl_ack pulses 3 cycles after req is sampled with dout=8'h3C; rom_cs then drops.
- ch_req=4'b1111 held continuously, with requesters re-raising req after the masked cycle -> grants 0,1,2,3,0 in order; exactly one ch_ack bit per access; one IDLE cycle between accesses.
- ch_req=4'b0110 and ctrl_req pulsed during channel 1's access -> channel 1 completes; the controller is granted next; then channel 2 (not channel 1).
- rom_ok held low 5 cycles after the settle period, then high -> ack arrives exactly on the first rom_ok cycle after SETTLE; a rom_ok pulse during SETTLE is ignored.
- TOUT=8, rom_ok stuck low -> ack and tout_err pulse together 8 cycles after WAIT is entered; dout=8'h00; the next request is then served.
- rst_n asserted during WAIT for channel 2 -> all outputs return to 0 asynchronously with no ack; after release, pending ch_req=4'b0101 grants channel 0 first.
